// File: rtl/axis_frame_gen.sv
// axis_frame_gen: AXI4-Stream master that emits runs of fixed-length frames of an
// incrementing word counter, with optional idle gaps between frames.
// Ports: m00_axis_aclk/m00_axis_aresetn (clock, async active-low reset),
//   start/num_frames/start_value (run request), m00_axis_t* (AXIS master),
//   busy/done (run status).
// Optional feature: define AXIS_FRAME_GEN_CHECKSUM_EN to replace each frame's tlast
//   payload with the XOR of that frame's preceding beats.
module axis_frame_gen #(
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_LEN              = 16,
  parameter int GAP_CYCLES             = 0
) (
  input  logic                                m00_axis_aclk,
  input  logic                                m00_axis_aresetn,
  input  logic                                start,
  input  logic [15:0]                         num_frames,
  input  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   start_value,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                busy,
  output logic                                done
);

  localparam int W  = C_M00_AXIS_TDATA_WIDTH;
  localparam int SW = C_M00_AXIS_TDATA_WIDTH / 8;
  localparam logic [15:0] LAST_BEAT = 16'(FRAME_LEN - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      rst_sync_q, rst_sync_d;
  logic [15:0]     num_frames_q, num_frames_d;
  logic [15:0]     frame_q, frame_d;
  logic [15:0]     beat_q, beat_d;
  logic [7:0]      gap_q, gap_d;
  logic [W-1:0]    word_q, word_d;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
  logic [W-1:0]    csum_q, csum_d;
`endif
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;
  logic [W-1:0]    tdata_q, tdata_d;
  logic [SW-1:0]   tstrb_q, tstrb_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            xfer;
  logic            last_beat;
  logic            accept;
  logic [15:0]     frame_next;

  // Start is only honoured once the reset release has propagated through two
  // flops, so a start present on the first edge after release is ignored.
  assign rst_sync_d = {rst_sync_q[0], 1'b1};
  assign xfer       = tvalid_q & m00_axis_tready;
  assign last_beat  = (beat_q == LAST_BEAT);
  assign accept     = (state_q == S_IDLE) && start && rst_sync_q[1];
  assign frame_next = frame_q + 16'd1;

  // State register
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (num_frames != 16'd0) ? S_SEND : S_DONE;
        end
      end
      S_SEND: begin
        if (xfer && last_beat) begin
          if (frame_next == num_frames_q) begin
            state_d = S_DONE;
          end else if (GAP_CYCLES > 0) begin
            state_d = S_GAP;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_SEND;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counters: only accepted starts and actual transfers move them.
  always_comb begin
    num_frames_d = num_frames_q;
    frame_d      = frame_q;
    beat_d       = beat_q;
    gap_d        = gap_q;
    word_d       = word_q;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    if (accept) begin
      num_frames_d = num_frames;
      word_d       = start_value;
      frame_d      = 16'd0;
      beat_d       = 16'd0;
      gap_d        = 8'd0;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
      csum_d       = '0;
`endif
    end
    if ((state_q == S_SEND) && xfer) begin
      if (last_beat) begin
        beat_d  = 16'd0;
        frame_d = frame_next;
        gap_d   = 8'd0;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
        // The checksum beat does not consume a counter value.
        csum_d  = '0;
`else
        word_d  = word_q + 1'b1;
`endif
      end else begin
        beat_d  = beat_q + 16'd1;
        word_d  = word_q + 1'b1;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
        csum_d  = csum_q ^ tdata_q;
`endif
      end
    end
    if (state_q == S_GAP) begin
      gap_d = gap_q + 8'd1;
    end
  end

  // Output logic: outputs are registered, so they are computed from the
  // next state and next counters. A stalled beat sees unchanged inputs here
  // and therefore holds.
  always_comb begin
    tvalid_d = (state_d == S_SEND);
    tlast_d  = (state_d == S_SEND) && (beat_d == LAST_BEAT);
    tdata_d  = tdata_q;
    tstrb_d  = tstrb_q;
    if (state_d == S_SEND) begin
      tstrb_d = '1;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
      tdata_d = tlast_d ? csum_d : word_d;
`else
      tdata_d = word_d;
`endif
    end
    busy_d = (state_d == S_SEND) || (state_d == S_GAP);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      rst_sync_q   <= 2'b00;
      num_frames_q <= 16'd0;
      frame_q      <= 16'd0;
      beat_q       <= 16'd0;
      gap_q        <= 8'd0;
      word_q       <= '0;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
      csum_q       <= '0;
`endif
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tdata_q      <= '0;
      tstrb_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      rst_sync_q   <= rst_sync_d;
      num_frames_q <= num_frames_d;
      frame_q      <= frame_d;
      beat_q       <= beat_d;
      gap_q        <= gap_d;
      word_q       <= word_d;
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tdata_q      <= tdata_d;
      tstrb_q      <= tstrb_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = tstrb_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_axis_frame_gen.sv
module tb_axis_frame_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: FRAME_LEN=4, no gap
  logic        a_start, a_tready, a_tvalid, a_tlast, a_busy, a_done;
  logic [15:0] a_num;
  logic [31:0] a_sv, a_tdata;
  logic [3:0]  a_tstrb;

  // Instance B: FRAME_LEN=2, GAP_CYCLES=3
  logic        b_start, b_tready, b_tvalid, b_tlast, b_busy, b_done;
  logic [15:0] b_num;
  logic [31:0] b_sv, b_tdata;
  logic [3:0]  b_tstrb;

  axis_frame_gen #(.C_M00_AXIS_TDATA_WIDTH(32), .FRAME_LEN(4), .GAP_CYCLES(0)) dut_a (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(a_start), .num_frames(a_num),
    .start_value(a_sv), .m00_axis_tready(a_tready), .m00_axis_tvalid(a_tvalid),
    .m00_axis_tlast(a_tlast), .m00_axis_tdata(a_tdata), .m00_axis_tstrb(a_tstrb),
    .busy(a_busy), .done(a_done));

  axis_frame_gen #(.C_M00_AXIS_TDATA_WIDTH(32), .FRAME_LEN(2), .GAP_CYCLES(3)) dut_b (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(b_start), .num_frames(b_num),
    .start_value(b_sv), .m00_axis_tready(b_tready), .m00_axis_tvalid(b_tvalid),
    .m00_axis_tlast(b_tlast), .m00_axis_tdata(b_tdata), .m00_axis_tstrb(b_tstrb),
    .busy(b_busy), .done(b_done));

  int checks = 0;
  int errors = 0;

  // Results of the last collect() call
  logic [31:0] q_dat[$];
  bit          q_last[$];
  int          q_cyc[$];
  int          done_cyc, done_cnt, stall_viol, strb_viol, timeout;
  logic        busy_at_done;

  task automatic start_run(input bit sel, input logic [15:0] n, input logic [31:0] sv);
    @(negedge clk);
    if (sel) begin b_start = 1'b1; b_num = n; b_sv = sv; end
    else     begin a_start = 1'b1; a_num = n; a_sv = sv; end
    @(posedge clk);
    #1;
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  // Records transfers cycle by cycle (cycle 0 = first negedge after start
  // acceptance) until two cycles past the first done pulse or the budget ends.
  task automatic collect(input bit sel, input bit bp, input int budget, input int restart_cyc);
    logic        v, l, d, bz, rdy, stalled, held_last;
    logic [31:0] dt, held_dat;
    logic [3:0]  sb;
    q_dat.delete(); q_last.delete(); q_cyc.delete();
    done_cyc = -1; done_cnt = 0; stall_viol = 0; strb_viol = 0; timeout = 0;
    busy_at_done = 1'b0; stalled = 1'b0; held_dat = '0; held_last = 1'b0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      v  = sel ? b_tvalid : a_tvalid;
      l  = sel ? b_tlast  : a_tlast;
      d  = sel ? b_done   : a_done;
      bz = sel ? b_busy   : a_busy;
      dt = sel ? b_tdata  : a_tdata;
      sb = sel ? b_tstrb  : a_tstrb;
      if (stalled && (v !== 1'b1 || dt !== held_dat || l !== held_last)) stall_viol++;
      if (d === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = bz; end
      end
      rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (sel) b_tready = rdy; else a_tready = rdy;
      if (restart_cyc >= 0) begin
        if (sel) begin b_start = (cyc == restart_cyc); b_num = 16'd5; b_sv = 32'h99; end
        else     begin a_start = (cyc == restart_cyc); a_num = 16'd5; a_sv = 32'h99; end
      end
      if (v === 1'b1 && rdy) begin
        q_dat.push_back(dt); q_last.push_back(l); q_cyc.push_back(cyc);
        if (sb !== 4'hF) strb_viol++;
      end
      stalled = (v === 1'b1) && !rdy;
      held_dat = dt; held_last = l;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    if (done_cyc < 0) timeout = 1;
    a_tready = 1'b1; b_tready = 1'b1; a_start = 1'b0; b_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_tvalid !== 1'b0 || a_tlast !== 1'b0 || a_tdata !== 32'h0 || a_tstrb !== 4'h0 ||
        a_busy !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got v=%b l=%b d=%h s=%h busy=%b done=%b, expected all zero",
               a_tvalid, a_tlast, a_tdata, a_tstrb, a_busy, a_done);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (b_tvalid !== 1'b0 || b_tdata !== 32'h0 || b_busy !== 1'b0 || b_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: got v=%b d=%h busy=%b done=%b, expected zero",
               b_tvalid, b_tdata, b_busy, b_done);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d [8];
    bit          exp_l [8];
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
    exp_d = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h13, 32'h14, 32'h15, 32'h12};
`else
    exp_d = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17};
`endif
    exp_l = '{0, 0, 0, 1, 0, 0, 0, 1};
    start_run(1'b0, 16'd2, 32'h10);
    collect(1'b0, 1'b0, 60, -1);
    checks++;
    if (timeout != 0) begin errors++; $display("FAIL b2b_timeout: no done within budget"); end
    checks++;
    if (q_dat.size() != 8) begin
      errors++; $display("FAIL b2b_count: got %0d beats, expected 8", q_dat.size());
    end
    for (int i = 0; i < 8 && i < q_dat.size(); i++) begin
      checks++;
      if (q_dat[i] !== exp_d[i] || q_last[i] !== exp_l[i] || q_cyc[i] != i) begin
        errors++;
        $display("FAIL b2b_beat[%0d]: got data=%h last=%b cyc=%0d, expected data=%h last=%b cyc=%0d",
                 i, q_dat[i], q_last[i], q_cyc[i], exp_d[i], exp_l[i], i);
      end
    end
    checks++;
    if (done_cyc != 8 || done_cnt != 1 || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: got cyc=%0d pulses=%0d busy=%b, expected cyc=8 pulses=1 busy=0",
               done_cyc, done_cnt, busy_at_done);
    end
    checks++;
    if (strb_viol != 0) begin errors++; $display("FAIL b2b_strb: got %0d bad strobes, expected 0", strb_viol); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d [8];
    bit          exp_l [8];
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
    exp_d = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h13, 32'h14, 32'h15, 32'h12};
`else
    exp_d = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16, 32'h17};
`endif
    exp_l = '{0, 0, 0, 1, 0, 0, 0, 1};
    start_run(1'b0, 16'd2, 32'h10);
    collect(1'b0, 1'b1, 100, -1);
    checks++;
    if (timeout != 0) begin errors++; $display("FAIL bp_timeout: no done within budget"); end
    checks++;
    if (q_dat.size() != 8) begin
      errors++; $display("FAIL bp_count: got %0d beats, expected 8", q_dat.size());
    end
    for (int i = 0; i < 8 && i < q_dat.size(); i++) begin
      checks++;
      if (q_dat[i] !== exp_d[i] || q_last[i] !== exp_l[i]) begin
        errors++;
        $display("FAIL bp_beat[%0d]: got data=%h last=%b, expected data=%h last=%b",
                 i, q_dat[i], q_last[i], exp_d[i], exp_l[i]);
      end
    end
    checks++;
    if (stall_viol != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_stall: got %0d unstable stalls, %0d done pulses, expected 0 and 1",
               stall_viol, done_cnt);
    end
  endtask

  task automatic test_gap_wrap();
    logic [31:0] exp_d [4];
    bit          exp_l [4];
    int          exp_c [4];
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
    exp_d = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
`else
    exp_d = '{32'hFFFFFFFF, 32'h0, 32'h1, 32'h2};
`endif
    exp_l = '{0, 1, 0, 1};
    exp_c = '{0, 1, 5, 6};
    start_run(1'b1, 16'd2, 32'hFFFFFFFF);
    collect(1'b1, 1'b0, 60, -1);
    checks++;
    if (q_dat.size() != 4) begin
      errors++; $display("FAIL gap_count: got %0d beats, expected 4", q_dat.size());
    end
    for (int i = 0; i < 4 && i < q_dat.size(); i++) begin
      checks++;
      if (q_dat[i] !== exp_d[i] || q_last[i] !== exp_l[i] || q_cyc[i] != exp_c[i]) begin
        errors++;
        $display("FAIL gap_beat[%0d]: got data=%h last=%b cyc=%0d, expected data=%h last=%b cyc=%0d",
                 i, q_dat[i], q_last[i], q_cyc[i], exp_d[i], exp_l[i], exp_c[i]);
      end
    end
    checks++;
    if (done_cyc != 7 || done_cnt != 1) begin
      errors++;
      $display("FAIL gap_done: got cyc=%0d pulses=%0d, expected cyc=7 pulses=1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_zero_frames();
    start_run(1'b0, 16'd0, 32'h55);
    collect(1'b0, 1'b0, 20, -1);
    checks++;
    if (q_dat.size() != 0) begin
      errors++; $display("FAIL zero_beats: got %0d beats, expected 0", q_dat.size());
    end
    checks++;
    if (done_cyc != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL zero_done: got cyc=%0d pulses=%0d, expected cyc=0 pulses=1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_reentry();
    logic [31:0] exp_d [4];
    exp_d = '{32'h40, 32'h41, 32'h42, 32'h43};
    start_run(1'b0, 16'd1, 32'h40);
    collect(1'b0, 1'b0, 40, 2);
    checks++;
    if (q_dat.size() != 4 || done_cyc != 4 || done_cnt != 1) begin
      errors++;
      $display("FAIL reentry_run: got beats=%0d done_cyc=%0d pulses=%0d, expected 4, 4, 1",
               q_dat.size(), done_cyc, done_cnt);
    end
    for (int i = 0; i < 4 && i < q_dat.size(); i++) begin
      checks++;
      if (q_dat[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL reentry_beat[%0d]: got %h expected %h", i, q_dat[i], exp_d[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b0 || a_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL reentry_idle: got busy=%b valid=%b, expected 0 0", a_busy, a_tvalid);
    end
  endtask

  task automatic test_reset_mid_frame();
    int seen;
    start_run(1'b0, 16'd2, 32'h20);
    repeat (3) @(negedge clk);
    checks++;
    if (a_tvalid !== 1'b1 || a_tdata !== 32'h22) begin
      errors++;
      $display("FAIL rmid_beat2: got valid=%b data=%h, expected 1 22", a_tvalid, a_tdata);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_tvalid !== 1'b0 || a_tdata !== 32'h0 || a_busy !== 1'b0 || a_tlast !== 1'b0) begin
      errors++;
      $display("FAIL rmid_async: got valid=%b data=%h busy=%b last=%b, expected 0 0 0 0",
               a_tvalid, a_tdata, a_busy, a_tlast);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_start = 1'b1; a_num = 16'd1; a_sv = 32'h77;
    @(posedge clk);
    #1 a_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_tvalid === 1'b1 || a_busy === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rmid_quiet: got %0d active cycles after release, expected 0", seen);
    end
    start_run(1'b0, 16'd1, 32'h30);
    collect(1'b0, 1'b0, 40, -1);
    checks++;
    if (q_dat.size() != 4 || (q_dat.size() > 0 && q_dat[0] !== 32'h30)) begin
      errors++;
      $display("FAIL rmid_restart: got %0d beats first=%h, expected 4 beats first=30",
               q_dat.size(), (q_dat.size() > 0) ? q_dat[0] : 32'h0);
    end
  endtask

`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
  task automatic test_checksum();
    logic [31:0] exp_d [8];
    exp_d = '{32'h1, 32'h2, 32'h3, 32'h0, 32'h4, 32'h5, 32'h6, 32'h7};
    start_run(1'b0, 16'd2, 32'h1);
    collect(1'b0, 1'b0, 60, -1);
    checks++;
    if (q_dat.size() != 8) begin
      errors++; $display("FAIL csum_count: got %0d beats, expected 8", q_dat.size());
    end
    for (int i = 0; i < 8 && i < q_dat.size(); i++) begin
      checks++;
      if (q_dat[i] !== exp_d[i] || q_last[i] !== ((i % 4) == 3)) begin
        errors++;
        $display("FAIL csum_beat[%0d]: got data=%h last=%b, expected data=%h last=%b",
                 i, q_dat[i], q_last[i], exp_d[i], ((i % 4) == 3));
      end
    end
  endtask
`endif

  initial begin
    a_start = 1'b0; a_num = '0; a_sv = '0; a_tready = 1'b1;
    b_start = 1'b0; b_num = '0; b_sv = '0; b_tready = 1'b1;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_gap_wrap();
    test_zero_frames();
    test_reentry();
    test_reset_mid_frame();
`ifdef AXIS_FRAME_GEN_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
